vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 128, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 88, horizontal back porch in clocks; H_TOTAL = 1056.
REQ-005 Parameter V_VISIBLE, default 600, active lines per frame.
REQ-006 Parameter V_FP, default 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 Parameter V_BP, default 23, vertical back porch in lines; V_TOTAL = 628.
REQ-009 Parameter SYNC_POL, default 1, active level of hsync and vsync.
REQ-010 clk  input  1  pixel clock, 40 MHz, rising-edge.
REQ-011 rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-012 en  input  1  advance enable; 0 freezes all state.
REQ-013 hcount  output  11  current pixel column, 0..H_TOTAL-1.
REQ-014 vcount  output  10  current line, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, SYNC_POL active.
REQ-016 vsync  output  1  vertical sync, SYNC_POL active.
REQ-017 hblnk  output  1  high when hcount >= H_VISIBLE.
REQ-018 vblnk  output  1  high when vcount >= V_VISIBLE.
REQ-019 frame_start  output  1  one-clock pulse when the counters wrap to (0,0).

Function
REQ-020 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-021 On each rising clk with en=1, hcount SHALL increment by 1, wrapping H_TOTAL-1 -> 0.
REQ-022 vcount SHALL increment only on the clock where hcount wraps, wrapping V_TOTAL-1 -> 0 on the same clock hcount wraps.
REQ-023 With en=0, hcount, vcount and all decoded outputs SHALL hold; frame_start SHALL be 0.
REQ-024 hblnk, vblnk, hsync, vsync SHALL describe the same pixel as hcount/vcount in the same cycle (zero skew); decode from next-count values.
REQ-025 hsync SHALL be active for H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (840..967 default).
REQ-026 vsync SHALL be active for V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (601..604 default), over whole lines.
REQ-027 frame_start SHALL be 1 exactly in the cycle where (hcount,vcount) = (0,0) reached by wrap, never after reset release.
REQ-028 Counter arithmetic SHALL be unsigned, widths 11/10 bits; totals exceeding width are a parameter error (elaboration assertion).
REQ-029 Downstream fixed-latency delay stage consumes these outputs unchanged; no extra pipeline stage inside this block.

Reset
REQ-030 rst=0 SHALL immediately (asynchronously) force hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, hsync=vsync=!SYNC_POL.
REQ-031 Reset release SHALL be synchronised by the integrator; first en=1 edge after release yields hcount=1, vcount=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; counting restarts from (0,0) with no frame_start pulse.

Structure
REQ-033 Default timing constants and H_TOTAL/V_TOTAL derivation SHALL live in shared package vga_timing_pkg, reused by the delay and draw stages.
REQ-034 No sub-module; the two counters and decode are inline.

Verification
REQ-035 Reset then en=1 for 1056 clocks -> hcount 0..1055 then 0, vcount 0 -> 1 at the wrap, hblnk rises at hcount=800.
REQ-036 Run one full frame (663168 clocks) -> frame_start high exactly once, at (0,0); vcount 627 -> 0 with hcount 1055 -> 0.
REQ-037 Check line 0 -> hsync active exactly for hcount 840..967 (128 clocks); vsync active for vcount 601..604 only.
REQ-038 Pulse en=0 for 10 clocks at hcount=500 -> hcount stays 500, outputs unchanged, resumes at 501.
REQ-039 Assert rst at (300,200) asynchronously between edges -> outputs zero/inactive before next edge; after release no frame_start, count restarts at 0.
REQ-040 SYNC_POL=0 -> hsync/vsync low only during sync windows and high in reset.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 800x600@60 timing constants and helpers, used by the timing
// generator and by the downstream delay and draw stages.
package vga_timing_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FP_DEF      = 40;
  localparam int H_SYNC_DEF    = 128;
  localparam int H_BP_DEF      = 88;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FP_DEF      = 1;
  localparam int V_SYNC_DEF    = 4;
  localparam int V_BP_DEF      = 23;

  localparam bit SYNC_POL_DEF  = 1'b1;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  // Decoded per-pixel flags, all describing the same (hcount, vcount).
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_decode_t;

  function automatic int axis_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  // True when value lies in [lo, lo+len).
  function automatic logic in_window(input int value, input int lo, input int len);
    return (value >= lo) && (value < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with sync and blanking
// decoded from the next-count values so every output is registered with zero skew.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                hblnk,
  output logic                vblnk,
  output logic                frame_start
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam hcount_t H_LAST = HCOUNT_W'(H_TOTAL - 1);
  localparam vcount_t V_LAST = VCOUNT_W'(V_TOTAL - 1);

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;

  if (H_TOTAL > (1 << HCOUNT_W) || H_TOTAL < 1) begin : g_h_total_check
    $error("vga_timing: horizontal total does not fit the 11-bit pixel counter");
  end
  if (V_TOTAL > (1 << VCOUNT_W) || V_TOTAL < 1) begin : g_v_total_check
    $error("vga_timing: vertical total does not fit the 10-bit line counter");
  end

  hcount_t     hcount_nxt;
  vcount_t     vcount_nxt;
  logic        h_wrap;
  logic        v_wrap;
  vga_decode_t dec_nxt;

  always_comb begin
    h_wrap     = (hcount == H_LAST);
    v_wrap     = (vcount == V_LAST);
    hcount_nxt = hcount + HCOUNT_W'(1);
    vcount_nxt = vcount;
    if (h_wrap) begin
      hcount_nxt = '0;
      vcount_nxt = v_wrap ? '0 : vcount + VCOUNT_W'(1);
    end
  end

  // Decode the pixel the counters are about to move to, so flags land with it.
  always_comb begin
    dec_nxt.hblnk = int'(hcount_nxt) >= H_VISIBLE;
    dec_nxt.vblnk = int'(vcount_nxt) >= V_VISIBLE;
    dec_nxt.hsync = in_window(int'(hcount_nxt), H_SYNC_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    dec_nxt.vsync = in_window(int'(vcount_nxt), V_SYNC_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      // Only a real wrap to (0,0) pulses; leaving reset at (0,0) does not.
      frame_start <= en && h_wrap && v_wrap;
      if (en) begin
        hcount <= hcount_nxt;
        vcount <= vcount_nxt;
        hblnk  <= dec_nxt.hblnk;
        vblnk  <= dec_nxt.vblnk;
        hsync  <= dec_nxt.hsync;
        vsync  <= dec_nxt.vsync;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default-size line checks plus a shrunken
// raster (16x8) for full-frame, reset and sync-polarity scenarios.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Default 800x600 instance
  logic        rst_d = 1'b0, en_d = 1'b0;
  logic [10:0] hcount_d;
  logic [9:0]  vcount_d;
  logic        hsync_d, vsync_d, hblnk_d, vblnk_d, frame_start_d;
  wire  [25:0] st_d = {hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d, frame_start_d};

  // Small raster: H 8+2+3+3=16, V 4+1+2+1=8, active-high sync
  logic        rst_s = 1'b0, en_s = 1'b0;
  logic [10:0] hcount_s;
  logic [9:0]  vcount_s;
  logic        hsync_s, vsync_s, hblnk_s, vblnk_s, frame_start_s;
  wire  [25:0] st_s = {hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s, frame_start_s};

  // Same small raster, active-low sync
  logic        rst_lo = 1'b0, en_lo = 1'b0;
  logic [10:0] hcount_lo;
  logic [9:0]  vcount_lo;
  logic        hsync_lo, vsync_lo, hblnk_lo, vblnk_lo, frame_start_lo;
  wire  [25:0] st_lo = {hcount_lo, vcount_lo, hsync_lo, vsync_lo, hblnk_lo, vblnk_lo, frame_start_lo};

  vga_timing dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .hcount(hcount_d), .vcount(vcount_d),
    .hsync(hsync_d), .vsync(vsync_d), .hblnk(hblnk_d), .vblnk(vblnk_d),
    .frame_start(frame_start_d)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .hblnk(hblnk_s), .vblnk(vblnk_s),
    .frame_start(frame_start_s)
  );

  vga_timing #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_lo (
    .clk(clk), .rst(rst_lo), .en(en_lo), .hcount(hcount_lo), .vcount(vcount_lo),
    .hsync(hsync_lo), .vsync(vsync_lo), .hblnk(hblnk_lo), .vblnk(vblnk_lo),
    .frame_start(frame_start_lo)
  );

  // Expected state of the 16x8 raster at a given position within the frame.
  function automatic logic [25:0] exp_small(input int pos, input bit pol);
    int  h, v;
    logic hs, vs;
    h  = pos % 16;
    v  = pos / 16;
    hs = (h >= 10 && h <= 12) ? pol : ~pol;
    vs = (v >= 5 && v <= 6) ? pol : ~pol;
    return {11'(h), 10'(v), hs, vs, logic'(h >= 8), logic'(v >= 4), 1'b0};
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (st_d !== 26'h0) $display("FAIL reset_default: got %h expected %h", st_d, 26'h0);
    else passed++;
    checks++;
    if (st_s !== 26'h0) $display("FAIL reset_small: got %h expected %h", st_s, 26'h0);
    else passed++;
    checks++;
    if (st_lo !== {11'd0, 10'd0, 1'b1, 1'b1, 3'b000})
      $display("FAIL reset_neg_pol: got %h expected %h", st_lo, {11'd0, 10'd0, 1'b1, 1'b1, 3'b000});
    else passed++;
  endtask

  task automatic test_line();
    logic [25:0] exp;
    int hs_cnt = 0;
    rst_d = 1'b1;
    en_d  = 1'b1;
    for (int i = 1; i < 1056; i++) begin
      @(posedge clk);
      #1;
      exp = {11'(i), 10'd0, logic'(i >= 840 && i < 968), 1'b0, logic'(i >= 800), 1'b0, 1'b0};
      checks++;
      if (st_d !== exp) $display("FAIL line0_px%0d: got %h expected %h", i, st_d, exp);
      else passed++;
      if (hsync_d) hs_cnt++;
    end
    checks++;
    if (hs_cnt !== 128) $display("FAIL hsync_width: got %0d expected 128", hs_cnt);
    else passed++;
    @(posedge clk);
    #1;
    exp = {11'd0, 10'd1, 5'b00000};
    checks++;
    if (st_d !== exp) $display("FAIL line_wrap: got %h expected %h", st_d, exp);
    else passed++;
  endtask

  task automatic test_enable_hold();
    logic [25:0] exp;
    repeat (500) @(posedge clk);
    #1;
    exp = {11'd500, 10'd1, 5'b00000};
    checks++;
    if (st_d !== exp) $display("FAIL at_500: got %h expected %h", st_d, exp);
    else passed++;
    en_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (st_d !== exp) $display("FAIL hold_500_%0d: got %h expected %h", i, st_d, exp);
      else passed++;
    end
    en_d = 1'b1;
    @(posedge clk);
    #1;
    exp = {11'd501, 10'd1, 5'b00000};
    checks++;
    if (st_d !== exp) $display("FAIL resume_501: got %h expected %h", st_d, exp);
    else passed++;
    // Hold again inside the sync pulse so decoded outputs are nonzero.
    repeat (399) @(posedge clk);
    #1;
    exp = {11'd900, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (st_d !== exp) $display("FAIL at_900: got %h expected %h", st_d, exp);
    else passed++;
    en_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (st_d !== exp) $display("FAIL hold_900_%0d: got %h expected %h", i, st_d, exp);
      else passed++;
    end
    en_d = 1'b1;
    @(posedge clk);
    #1;
    exp = {11'd901, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (st_d !== exp) $display("FAIL resume_901: got %h expected %h", st_d, exp);
    else passed++;
  endtask

  task automatic test_frame();
    logic [25:0] exp;
    int fs_cnt = 0;
    rst_s = 1'b1;
    en_s  = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      exp = exp_small(k % 128, 1'b1);
      exp[0] = ((k % 128) == 0);
      checks++;
      if (st_s !== exp) $display("FAIL frame_k%0d: got %h expected %h", k, st_s, exp);
      else passed++;
      if (frame_start_s) fs_cnt++;
    end
    checks++;
    if (fs_cnt !== 2) $display("FAIL frame_start_count: got %0d expected 2", fs_cnt);
    else passed++;
  endtask

  task automatic test_enable_at_wrap();
    logic [25:0] exp;
    repeat (127) @(posedge clk);
    #1;
    en_s = 1'b0;
    exp  = {11'd15, 10'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (st_s !== exp) $display("FAIL hold_at_wrap_%0d: got %h expected %h", i, st_s, exp);
      else passed++;
    end
    en_s = 1'b1;
    @(posedge clk);
    #1;
    exp = {11'd0, 10'd0, 4'b0000, 1'b1};
    checks++;
    if (st_s !== exp) $display("FAIL wrap_after_hold: got %h expected %h", st_s, exp);
    else passed++;
    @(posedge clk);
    #1;
    exp = {11'd1, 10'd0, 5'b00000};
    checks++;
    if (st_s !== exp) $display("FAIL pulse_one_clock: got %h expected %h", st_s, exp);
    else passed++;
  endtask

  task automatic test_async_reset();
    logic [25:0] exp;
    repeat (90) @(posedge clk);
    #1;
    exp = {11'd11, 10'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (st_s !== exp) $display("FAIL pre_reset_11_5: got %h expected %h", st_s, exp);
    else passed++;
    #3;
    rst_s = 1'b0;
    #1;
    checks++;
    if (st_s !== 26'h0) $display("FAIL async_reset: got %h expected %h", st_s, 26'h0);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (st_s !== 26'h0) $display("FAIL reset_held: got %h expected %h", st_s, 26'h0);
    else passed++;
    rst_s = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(posedge clk);
      #1;
      exp = exp_small(k % 128, 1'b1);
      exp[0] = ((k % 128) == 0);
      checks++;
      if (st_s !== exp) $display("FAIL restart_k%0d: got %h expected %h", k, st_s, exp);
      else passed++;
    end
  endtask

  task automatic test_sync_pol();
    logic [25:0] exp;
    rst_lo = 1'b1;
    en_lo  = 1'b1;
    for (int k = 1; k <= 139; k++) begin
      @(posedge clk);
      #1;
      exp = exp_small(k % 128, 1'b0);
      exp[0] = ((k % 128) == 0);
      checks++;
      if (st_lo !== exp) $display("FAIL negpol_k%0d: got %h expected %h", k, st_lo, exp);
      else passed++;
    end
    // Now at (11,0) with hsync active-low; reset must drive it back high.
    #3;
    rst_lo = 1'b0;
    #1;
    exp = {11'd0, 10'd0, 1'b1, 1'b1, 3'b000};
    checks++;
    if (st_lo !== exp) $display("FAIL negpol_reset: got %h expected %h", st_lo, exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_enable_hold();
    test_frame();
    test_enable_at_wrap();
    test_async_reset();
    test_sync_pol();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
